// File: rtl/gnss_pkg.sv
// Shared definitions for the multi-tap GNSS correlator channel.
// Holds the default channel dimensions, the config register map and the
// control/code-config bit positions used by the bank and its testbench.
package gnss_pkg;

  // Default channel dimensions
  localparam int unsigned DEF_NTAPS      = 3;
  localparam int unsigned DEF_INTEG_BITS = 18;
  localparam int unsigned DEF_CODE_BITS  = 13;
  localparam int unsigned DEF_NCO_BITS   = 32;

  // Config register map
  typedef enum logic [1:0] {
    CFG_LO   = 2'd0,
    CFG_CG   = 2'd1,
    CFG_CODE = 2'd2,
    CFG_CTRL = 2'd3
  } cfg_addr_e;

  // Control register bit positions
  localparam int unsigned PAUSE   = 0;
  localparam int unsigned CLR_OVR = 1;

  // BOC enable bit inside the code config word
  localparam int unsigned BOC_BIT = 16;

endpackage

// File: rtl/gnss_iq_acc.sv
// One correlator tap: wipes the 1-bit sample with the tap's code chip and the
// quadrature LO, then integrates +/-1 per cycle into signed I and Q sums.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sample            1-bit IF sample
//   tap               code chip seen by this tap
//   lo_i, lo_q        quadrature square-wave LO
//   dump              restart the sums at this cycle's contribution
//   acc_i, acc_q      running I/Q integrals (two's complement, wrapping)
module gnss_iq_acc
  import gnss_pkg::*;
#(
  parameter int unsigned INTEG_BITS = DEF_INTEG_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample,
  input  logic                  tap,
  input  logic                  lo_i,
  input  logic                  lo_q,
  input  logic                  dump,
  output logic [INTEG_BITS-1:0] acc_i,
  output logic [INTEG_BITS-1:0] acc_q
);

  logic                  d_i;
  logic                  d_q;
  logic [INTEG_BITS-1:0] step_i;
  logic [INTEG_BITS-1:0] step_q;

  // Mixer: XOR of sample, chip and LO maps to -1 when set, +1 when clear
  always_comb begin
    d_i    = sample ^ tap ^ lo_i;
    d_q    = sample ^ tap ^ lo_q;
    step_i = d_i ? {INTEG_BITS{1'b1}} : INTEG_BITS'(1);
    step_q = d_q ? {INTEG_BITS{1'b1}} : INTEG_BITS'(1);
  end

  // Integrate-and-dump; a dump keeps the current cycle's contribution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (dump) begin
      acc_i <= step_i;
      acc_q <= step_q;
    end else begin
      acc_i <= acc_i + step_i;
      acc_q <= acc_q + step_q;
    end
  end

endmodule

// File: rtl/gnss_corr_bank.sv
// Multi-tap GNSS correlator channel: carrier NCO with quadrature square-wave
// LO, code NCO pacing an external code generator, a half-chip-spaced code
// delay line, NTAPS I/Q integrate-and-dump taps and an epoch-latched serial
// readout shadow.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sample            1-bit IF sample
//   cfg_we/addr/data  config write (0 lo_rate, 1 cg_rate, 2 code config, 3 ctrl)
//   cg_resume         restarts a paused code NCO
//   code_chip         current chip from the external code generator
//   code_rd           advance request to the code generator (combinational)
//   nchip             current chip index
//   epoch             one-cycle pulse after the code wraps
//   dump_rdy          shadow holds an unread dump
//   overrun           sticky: a dump was overwritten unread
//   shift, sout       serial readout strobe and data (shadow MSB)
module gnss_corr_bank
  import gnss_pkg::*;
#(
  parameter int unsigned NTAPS      = DEF_NTAPS,
  parameter int unsigned INTEG_BITS = DEF_INTEG_BITS,
  parameter int unsigned CODE_BITS  = DEF_CODE_BITS,
  parameter int unsigned NCO_BITS   = DEF_NCO_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [31:0]          cfg_data,
  input  logic                 cg_resume,
  input  logic                 code_chip,
  output logic                 code_rd,
  output logic [CODE_BITS-1:0] nchip,
  output logic                 epoch,
  output logic                 dump_rdy,
  output logic                 overrun,
  input  logic                 shift,
  output logic                 sout
);

  localparam int unsigned SH_W = 2 * NTAPS * INTEG_BITS;

  // Configuration state
  logic [NCO_BITS-1:0]  lo_rate;
  logic [NCO_BITS-1:0]  cg_rate;
  logic [CODE_BITS-1:0] code_len;
  logic                 boc;
  logic                 cg_en;

  // NCOs, delay line and readout state
  logic [NCO_BITS-1:0]  lo_phase;
  logic [NCO_BITS-1:0]  cg_phase;
  logic [NTAPS-1:0]     taps;
  logic [SH_W-1:0]      shadow;
  logic [SH_W-1:0]      dump_word;

  // Combinational decode
  logic                 wr_lo;
  logic                 wr_cg;
  logic                 wr_code;
  logic                 wr_ctrl;
  logic [NCO_BITS:0]    cg_sum;
  logic                 half_carry;
  logic                 full_tick;
  logic                 half_tick;
  logic                 chip_wrap;
  logic                 delay_in;
  logic                 lo_i;
  logic                 lo_q;

  // Config write decode
  always_comb begin
    wr_lo   = cfg_we && (cfg_addr == CFG_LO);
    wr_cg   = cfg_we && (cfg_addr == CFG_CG);
    wr_code = cfg_we && (cfg_addr == CFG_CODE);
    wr_ctrl = cfg_we && (cfg_addr == CFG_CTRL);
  end

  // Code NCO ticks: carry out of the MSB is a full chip, carry into the MSB
  // (recovered from the sum bit) is a half chip; full ticks count as half too
  always_comb begin
    cg_sum     = {1'b0, cg_phase} + {1'b0, cg_rate};
    half_carry = cg_sum[NCO_BITS-1] ^ cg_phase[NCO_BITS-1] ^ cg_rate[NCO_BITS-1];
    full_tick  = cg_en & cg_sum[NCO_BITS];
    half_tick  = cg_en & (half_carry | cg_sum[NCO_BITS]);
    chip_wrap  = (nchip >= code_len);
    delay_in   = code_chip ^ (boc & cg_phase[NCO_BITS-1]);
    lo_i       = lo_phase[NCO_BITS-1];
    lo_q       = lo_phase[NCO_BITS-1] ^ lo_phase[NCO_BITS-2];
  end

  assign code_rd = full_tick;
  assign sout    = shadow[SH_W-1];

  // Config registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_rate  <= '0;
      cg_rate  <= '0;
      code_len <= '0;
      boc      <= 1'b0;
    end else begin
      if (wr_lo) lo_rate <= cfg_data[NCO_BITS-1:0];
      if (wr_cg) cg_rate <= cfg_data[NCO_BITS-1:0];
      if (wr_code) begin
        code_len <= cfg_data[CODE_BITS-1:0];
        boc      <= cfg_data[BOC_BIT];
      end
    end
  end

  // Code NCO enable: a pause write wins over a simultaneous resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cg_en <= 1'b1;
    end else if (wr_ctrl && cfg_data[PAUSE]) begin
      cg_en <= 1'b0;
    end else if (!cg_en && cg_resume) begin
      cg_en <= 1'b1;
    end
  end

  // Carrier NCO runs freely; code NCO holds while paused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_phase <= '0;
      cg_phase <= '0;
    end else begin
      lo_phase <= lo_phase + lo_rate;
      if (cg_en) cg_phase <= cg_sum[NCO_BITS-1:0];
    end
  end

  // Chip counter; >= lets a shortened code wrap on the next tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nchip <= '0;
      epoch <= 1'b0;
    end else begin
      epoch <= full_tick & chip_wrap;
      if (full_tick) begin
        if (chip_wrap) nchip <= '0;
        else           nchip <= nchip + CODE_BITS'(1);
      end
    end
  end

  // Half-chip delay line, tap 0 holds the newest (earliest) chip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (half_tick) begin
      taps <= {taps[NTAPS-2:0], delay_in};
    end
  end

  // Per-tap mixers and accumulators, packed MSB-first as I0,Q0,I1,Q1,...
  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [INTEG_BITS-1:0] acc_i;
    logic [INTEG_BITS-1:0] acc_q;

    gnss_iq_acc #(
      .INTEG_BITS (INTEG_BITS)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .sample (sample),
      .tap    (taps[k]),
      .lo_i   (lo_i),
      .lo_q   (lo_q),
      .dump   (epoch),
      .acc_i  (acc_i),
      .acc_q  (acc_q)
    );

    assign dump_word[SH_W-1-(2*k)*INTEG_BITS -: INTEG_BITS]   = acc_i;
    assign dump_word[SH_W-1-(2*k+1)*INTEG_BITS -: INTEG_BITS] = acc_q;
  end

  // Readout shadow: a load in the dump cycle takes priority over a shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      dump_rdy <= 1'b0;
    end else if (epoch) begin
      shadow   <= dump_word;
      dump_rdy <= 1'b1;
    end else if (shift) begin
      shadow   <= {shadow[SH_W-2:0], 1'b0};
      dump_rdy <= 1'b0;
    end
  end

  // Overrun: a fresh overwrite wins over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (epoch && dump_rdy) begin
      overrun <= 1'b1;
    end else if (wr_ctrl && cfg_data[CLR_OVR]) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gnss_corr_bank.sv
// Testbench for gnss_corr_bank: directed scenarios plus a randomized run,
// all cross-checked every cycle against a cycle-level arithmetic model.
module tb_gnss_corr_bank;

  localparam int NTAPS = 3;
  localparam int IB    = 18;
  localparam int CB    = 13;
  localparam int NB    = 32;
  localparam int SH_W  = 2 * NTAPS * IB;
  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint TWO31 = 64'h8000_0000;
  localparam longint TWO30 = 64'h4000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_data;
  logic          cg_resume;
  logic          code_chip;
  logic          code_rd;
  logic [CB-1:0] nchip;
  logic          epoch;
  logic          dump_rdy;
  logic          overrun;
  logic          shift;
  logic          sout;

  gnss_corr_bank #(
    .NTAPS(NTAPS), .INTEG_BITS(IB), .CODE_BITS(CB), .NCO_BITS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cg_resume(cg_resume),
    .code_chip(code_chip), .code_rd(code_rd), .nchip(nchip), .epoch(epoch),
    .dump_rdy(dump_rdy), .overrun(overrun), .shift(shift), .sout(sout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  longint m_lo_phase, m_lo_rate, m_cg_phase, m_cg_rate;
  int     m_code_len, m_nchip;
  bit     m_boc, m_cg_en, m_epoch, m_dump_rdy, m_overrun;
  bit     m_tap [NTAPS];
  int     m_acc_i [NTAPS];
  int     m_acc_q [NTAPS];
  bit     m_sh [$];

  logic [IB-1:0] rd_val [2*NTAPS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lo_phase = 0; m_lo_rate = 0; m_cg_phase = 0; m_cg_rate = 0;
    m_code_len = 0; m_nchip = 0;
    m_boc = 0; m_cg_en = 1; m_epoch = 0; m_dump_rdy = 0; m_overrun = 0;
    for (int k = 0; k < NTAPS; k++) begin
      m_tap[k] = 0; m_acc_i[k] = 0; m_acc_q[k] = 0;
    end
    m_sh.delete();
    for (int n = 0; n < SH_W; n++) m_sh.push_back(1'b0);
  endtask

  function automatic bit m_full();
    return m_cg_en && ((m_cg_phase + m_cg_rate) >= TWO32);
  endfunction

  // One clock edge of the channel, computed from the rules with plain arithmetic
  task automatic model_step();
    bit full, half, li, lq, e, dump, was_rdy, wr3;
    int ci [NTAPS];
    int cq [NTAPS];
    full = m_full();
    half = m_cg_en && ((((m_cg_phase % TWO31) + (m_cg_rate % TWO31)) >= TWO31) || full);
    li   = (m_lo_phase >= TWO31);
    lq   = li ^ bit'((m_lo_phase / TWO30) % 2);
    e    = code_chip ^ (m_boc & (m_cg_phase >= TWO31));
    for (int k = 0; k < NTAPS; k++) begin
      ci[k] = (sample ^ m_tap[k] ^ li) ? -1 : 1;
      cq[k] = (sample ^ m_tap[k] ^ lq) ? -1 : 1;
    end
    dump    = m_epoch;
    was_rdy = m_dump_rdy;
    wr3     = cfg_we && (cfg_addr == 2'd3);

    m_epoch = full && (m_nchip >= m_code_len);
    if (full) m_nchip = (m_nchip >= m_code_len) ? 0 : m_nchip + 1;
    m_lo_phase = (m_lo_phase + m_lo_rate) % TWO32;
    if (m_cg_en) m_cg_phase = (m_cg_phase + m_cg_rate) % TWO32;
    if (half) begin
      for (int k = NTAPS - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = e;
    end

    if (dump) begin
      m_sh.delete();
      for (int k = 0; k < NTAPS; k++) begin
        for (int b = IB - 1; b >= 0; b--) m_sh.push_back(bit'((m_acc_i[k] >> b) & 1));
        for (int b = IB - 1; b >= 0; b--) m_sh.push_back(bit'((m_acc_q[k] >> b) & 1));
        m_acc_i[k] = ci[k];
        m_acc_q[k] = cq[k];
      end
      m_dump_rdy = 1;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        m_acc_i[k] += ci[k];
        m_acc_q[k] += cq[k];
      end
      if (shift) begin
        void'(m_sh.pop_front());
        m_sh.push_back(1'b0);
        m_dump_rdy = 0;
      end
    end

    if (wr3 && cfg_data[1]) m_overrun = 0;
    if (dump && was_rdy) m_overrun = 1;
    if (wr3 && cfg_data[0]) m_cg_en = 0;
    else if (!m_cg_en && cg_resume) m_cg_en = 1;

    if (cfg_we && cfg_addr == 2'd0) m_lo_rate = longint'(cfg_data);
    if (cfg_we && cfg_addr == 2'd1) m_cg_rate = longint'(cfg_data);
    if (cfg_we && cfg_addr == 2'd2) begin
      m_code_len = int'(cfg_data[CB-1:0]);
      m_boc      = cfg_data[16];
    end
  endtask

  // Enter just after a posedge; leave just after the next one
  task automatic tick();
    #1;
    check("code_rd", code_rd, m_full());
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("nchip", nchip, m_nchip);
    check("epoch", epoch, m_epoch);
    check("dump_rdy", dump_rdy, m_dump_rdy);
    check("overrun", overrun, m_overrun);
    check("sout", sout, m_sh[0]);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = '0;
  endtask

  task automatic wait_epoch();
    int n = 0;
    do begin
      tick();
      n++;
    end while (epoch !== 1'b1 && n < 200);
    check("epoch_timeout", (n < 200), 1);
  endtask

  task automatic readout();
    for (int i = 0; i < 2*NTAPS; i++) rd_val[i] = '0;
    for (int n = 0; n < SH_W; n++) begin
      rd_val[n/IB] = {rd_val[n/IB][IB-2:0], sout};
      shift = 1'b1;
      tick();
      if (n == 0) check("first_shift_clears_rdy", dump_rdy, 0);
    end
    shift = 1'b0;
  endtask

  task automatic resume();
    cg_resume = 1'b1;
    tick();
    cg_resume = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, n, p, r;
    rst_n = 1'b0; sample = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    cg_resume = 0; code_chip = 0; shift = 0;
    model_reset();
    #2;
    check("rst_code_rd", code_rd, 0);
    check("rst_nchip", nchip, 0);
    check("rst_epoch", epoch, 0);
    check("rst_dump_rdy", dump_rdy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sout", sout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic epoch timing: quarter-rate code NCO, 10-chip code
    cfg_write(2'd0, 32'd0);
    cfg_write(2'd1, 32'h4000_0000);
    cfg_write(2'd2, 32'd9);
    wait_epoch(); c1 = cyc;
    wait_epoch();
    check("epoch_period", cyc - c1, 40);
    tick();
    check("dump_rdy_after_dump", dump_rdy, 1);
    cfg_write(2'd3, 32'd3);
    readout();
    for (int i = 0; i < 2*NTAPS; i++) check("plus40", rd_val[i], 40);

    // Serial value with sample = 1, plus overrun across two unread dumps
    sample = 1'b1;
    resume();
    wait_epoch(); tick();
    check("no_overrun_single", overrun, 0);
    wait_epoch(); tick();
    check("overrun_set", overrun, 1);
    cfg_write(2'd3, 32'd2);
    check("overrun_clr", overrun, 0);
    cfg_write(2'd3, 32'd1);
    readout();
    for (int i = 0; i < 2*NTAPS; i++) check("minus40", rd_val[i], 18'h3FFD8);

    // Pause holds the code NCO for 20 cycles
    p = m_nchip;
    repeat (20) begin
      tick();
      check("pause_nchip", nchip, p);
      check("pause_code_rd", code_rd, 0);
    end
    resume();
    n = 0;
    while (code_rd !== 1'b1 && n < 8) begin tick(); n++; end
    check("resume_advance", (n < 8), 1);

    // Load/shift collision in the dump cycle
    sample = 1'b0;
    wait_epoch();
    wait_epoch();
    shift = 1'b1;
    tick();
    shift = 1'b0;
    check("collision_rdy", dump_rdy, 1);
    cfg_write(2'd3, 32'd3);
    readout();
    for (int i = 0; i < 2*NTAPS; i++) check("collision_val", rd_val[i], 40);

    // BOC: alternating half-chip taps integrate to zero
    cfg_write(2'd2, 32'h0001_0009);
    resume();
    wait_epoch(); wait_epoch(); wait_epoch();
    tick();
    cfg_write(2'd3, 32'd3);
    readout();
    for (int i = 0; i < 2*NTAPS; i++) check("boc_zero", rd_val[i], 0);

    // Asynchronous reset in the middle of a readout
    resume();
    wait_epoch(); tick();
    shift = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0; shift = 1'b0;
    #1;
    model_reset();
    check("arst_code_rd", code_rd, 0);
    check("arst_nchip", nchip, 0);
    check("arst_epoch", epoch, 0);
    check("arst_dump_rdy", dump_rdy, 0);
    check("arst_overrun", overrun, 0);
    check("arst_sout", sout, 0);
    @(posedge clk); #1;
    check("arst_hold_nchip", nchip, 0);
    rst_n = 1'b1;

    // Randomized run against the model
    cfg_write(2'd0, $urandom);
    cfg_write(2'd1, $urandom_range(32'h7FFF_FFFF, 32'h2000_0000));
    cfg_write(2'd2, {15'd0, 1'($urandom_range(1, 0)), 12'd0, 4'($urandom_range(7, 2))});
    for (int i = 0; i < 3000; i++) begin
      sample    = 1'($urandom);
      code_chip = 1'($urandom);
      shift     = ($urandom_range(99, 0) < 5);
      cg_resume = ($urandom_range(99, 0) < 10);
      r = int'($urandom_range(99, 0));
      if (r < 3 && !m_epoch) begin
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 32'($urandom_range(3, 0));
        cg_resume = 1'b0;
      end else if (r < 6) begin
        cfg_we = 1'b1; cfg_addr = 2'd2;
        cfg_data = {15'd0, 1'($urandom_range(1, 0)), 12'd0, 4'($urandom_range(15, 0))};
      end else if (r < 8) begin
        cfg_we = 1'b1; cfg_addr = 2'd1;
        cfg_data = $urandom_range(32'h7FFF_FFFF, 32'h2000_0000);
      end else if (r < 9) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = $urandom;
      end
      tick();
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
